mmc3_scanline_irq: RTL and testbench

- MMC3-style scanline IRQ generator for the mapper logic that feeds the top-level `irq` output.
- Watches PPU A12. Each filtered rising edge is one scanline clock, which decrements an 8-bit counter reloaded from a CPU-written latch.
- Raises a sticky IRQ when the counter reaches zero while IRQs are enabled.
- Shared by the MMC3 family, 118 and 189 modes; the register decode upstream supplies one-cycle write strobes.

---
 rtl/coolgirl_pkg.sv | 21 ++
 rtl/a12_edge_filter.sv | 43 ++++
 rtl/mmc3_scanline_irq.sv | 103 ++++++++++
 tb/tb_mmc3_scanline_irq.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/coolgirl_pkg.sv
// Shared constants for the mapper IRQ logic: register selects, filter defaults,
// and the saturating counter helper used by the A12 low-time filter.
package coolgirl_pkg;

  localparam logic [1:0] REG_IRQ_LATCH   = 2'd0;
  localparam logic [1:0] REG_IRQ_RELOAD  = 2'd1;
  localparam logic [1:0] REG_IRQ_DISABLE = 2'd2;
  localparam logic [1:0] REG_IRQ_ENABLE  = 2'd3;

  localparam int         A12_LOW_CYCLES_DEFAULT = 3;
  localparam logic [3:0] LOW_CNT_MAX            = 4'd15;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    if (value == LOW_CNT_MAX) begin
      return value;
    end else begin
      return value + 4'd1;
    end
  endfunction

endpackage

// File: rtl/a12_edge_filter.sv
// Synchronizes PPU A12 into the m2 domain and emits a one-cycle scanline clock
// on rises that follow a long enough low period (rejects sprite-fetch toggles).
module a12_edge_filter
  import coolgirl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int A12_LOW_CYCLES = A12_LOW_CYCLES_DEFAULT
) (
  input  logic m2,
  input  logic rst_n,
  input  logic enable,
  input  logic ppu_a12,
  output logic clk_ev
);

  localparam logic [3:0] LOW_THRESH = 4'(A12_LOW_CYCLES);

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   a12_prev_r;
  logic [3:0]             low_cnt_r;
  logic                   a12_s;

  assign a12_s  = sync_r[SYNC_STAGES-1];
  assign clk_ev = a12_s & ~a12_prev_r & (low_cnt_r >= LOW_THRESH);

  // Synchronizer chain, edge history and low-time counter
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      sync_r     <= '0;
      a12_prev_r <= 1'b0;
      low_cnt_r  <= 4'd0;
    end else if (!enable) begin
      sync_r     <= '0;
      a12_prev_r <= 1'b0;
      low_cnt_r  <= 4'd0;
    end else begin
      sync_r     <= {sync_r[SYNC_STAGES-2:0], ppu_a12};
      a12_prev_r <= a12_s;
      low_cnt_r  <= a12_s ? 4'd0 : sat_inc4(low_cnt_r);
    end
  end

endmodule

// File: rtl/mmc3_scanline_irq.sv
// MMC3-style scanline IRQ: a filtered A12 rise clocks an 8-bit down counter
// reloaded from a CPU latch; reaching zero with IRQs enabled raises a sticky irq.
module mmc3_scanline_irq
  import coolgirl_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int A12_LOW_CYCLES = A12_LOW_CYCLES_DEFAULT,
  parameter bit NEW_STYLE      = 1'b1
) (
  input  logic       m2,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       ppu_a12,
  input  logic       wr_stb,
  input  logic [1:0] reg_sel,
  input  logic [7:0] wr_data,
  output logic       irq,
  output logic [7:0] counter
);

  logic [7:0] latch_r, counter_r;
  logic       reload_r, irq_en_r, irq_r;
  logic [7:0] latch_s, counter_s, ev_cnt_s;
  logic       reload_s, irq_en_s, irq_s;
  logic       clk_ev_s, ev_load_s, armed_s, irq_set_s;

  a12_edge_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .A12_LOW_CYCLES(A12_LOW_CYCLES)
  ) u_filter (
    .m2     (m2),
    .rst_n  (rst_n),
    .enable (enable),
    .ppu_a12(ppu_a12),
    .clk_ev (clk_ev_s)
  );

  assign ev_load_s = (counter_r == 8'd0) || reload_r;
  assign ev_cnt_s  = ev_load_s ? latch_r : (counter_r - 8'd1);
  // Old-style parts only fire when zero is freshly reached or reloaded
  assign armed_s   = NEW_STYLE ? 1'b1 : ((counter_r != 8'd0) || reload_r);
  assign irq_set_s = clk_ev_s && irq_en_r && (ev_cnt_s == 8'd0) && armed_s;

  // Next state: scanline event first, then any CPU write overrides its fields
  always_comb begin
    latch_s   = latch_r;
    counter_s = counter_r;
    reload_s  = reload_r;
    irq_en_s  = irq_en_r;
    irq_s     = irq_r;
    if (clk_ev_s) begin
      counter_s = ev_cnt_s;
      reload_s  = 1'b0;
      irq_s     = irq_r | irq_set_s;
    end else begin
      counter_s = counter_r;
    end
    if (wr_stb) begin
      case (reg_sel)
        REG_IRQ_LATCH: latch_s = wr_data;
        REG_IRQ_RELOAD: begin
          counter_s = 8'd0;
          reload_s  = 1'b1;
        end
        REG_IRQ_DISABLE: begin
          irq_en_s = 1'b0;
          irq_s    = 1'b0;
        end
        REG_IRQ_ENABLE: irq_en_s = 1'b1;
        default: latch_s = latch_r;
      endcase
    end else begin
      latch_s = latch_r;
    end
  end

  // Counter, latch and IRQ state; a deselected mapper mode holds reset values
  always_ff @(posedge m2 or negedge rst_n) begin
    if (!rst_n) begin
      latch_r   <= 8'd0;
      counter_r <= 8'd0;
      reload_r  <= 1'b0;
      irq_en_r  <= 1'b0;
      irq_r     <= 1'b0;
    end else if (!enable) begin
      latch_r   <= 8'd0;
      counter_r <= 8'd0;
      reload_r  <= 1'b0;
      irq_en_r  <= 1'b0;
      irq_r     <= 1'b0;
    end else begin
      latch_r   <= latch_s;
      counter_r <= counter_s;
      reload_r  <= reload_s;
      irq_en_r  <= irq_en_s;
      irq_r     <= irq_s;
    end
  end

  assign irq     = irq_r;
  assign counter = counter_r;

endmodule

// File: tb/tb_mmc3_scanline_irq.sv
// Bench for mmc3_scanline_irq: old- and new-style instances share stimulus and are
// checked every cycle against a behavioural model, plus hand-computed spot checks.
module tb_mmc3_scanline_irq;

  localparam int S = 2;
  localparam int L = 3;

  logic       m2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       ppu_a12 = 1'b0;
  logic       wr_stb = 1'b0;
  logic [1:0] reg_sel = 2'd0;
  logic [7:0] wr_data = 8'd0;
  logic       irq0, irq1;
  logic [7:0] cnt0, cnt1;

  int nvec = 0;
  int nerr = 0;

  always #5 m2 = ~m2;

  mmc3_scanline_irq #(.SYNC_STAGES(S), .A12_LOW_CYCLES(L), .NEW_STYLE(1'b0)) dut_old (
    .m2(m2), .rst_n(rst_n), .enable(enable), .ppu_a12(ppu_a12), .wr_stb(wr_stb),
    .reg_sel(reg_sel), .wr_data(wr_data), .irq(irq0), .counter(cnt0));

  mmc3_scanline_irq #(.SYNC_STAGES(S), .A12_LOW_CYCLES(L), .NEW_STYLE(1'b1)) dut_new (
    .m2(m2), .rst_n(rst_n), .enable(enable), .ppu_a12(ppu_a12), .wr_stb(wr_stb),
    .reg_sel(reg_sel), .wr_data(wr_data), .irq(irq1), .counter(cnt1));

  // Behavioural model: index 0 = old style, 1 = new style
  int m_cnt[2]   = '{0, 0};
  int m_latch[2] = '{0, 0};
  bit m_rel[2]   = '{0, 0};
  bit m_en[2]    = '{0, 0};
  bit m_irq[2]   = '{0, 0};
  bit a12_q[$];
  bit last_seen  = 1'b0;
  int zrun       = 0;

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_cnt[s] = 0; m_latch[s] = 0; m_rel[s] = 1'b0; m_en[s] = 1'b0; m_irq[s] = 1'b0;
    end
    a12_q.delete();
    for (int i = 0; i < S; i++) a12_q.push_back(1'b0);
    last_seen = 1'b0;
    zrun = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge m2 or negedge rst_n);
      if (!rst_n || !enable) begin
        model_clear();
      end else begin
        bit seen, ev;
        seen = a12_q.pop_front();
        a12_q.push_back(ppu_a12);
        ev = seen && !last_seen && (zrun >= L);
        zrun = seen ? 0 : ((zrun < 15) ? zrun + 1 : 15);
        last_seen = seen;
        for (int s = 0; s < 2; s++) begin
          int old_c;
          bit old_r;
          old_c = m_cnt[s];
          old_r = m_rel[s];
          if (ev) begin
            if (old_c == 0 || old_r) begin
              m_cnt[s] = m_latch[s];
              m_rel[s] = 1'b0;
            end else begin
              m_cnt[s] = old_c - 1;
            end
            if (m_cnt[s] == 0 && m_en[s] && (s == 1 || old_c != 0 || old_r)) m_irq[s] = 1'b1;
          end
          if (wr_stb) begin
            case (reg_sel)
              2'd0: m_latch[s] = int'(wr_data);
              2'd1: begin m_cnt[s] = 0; m_rel[s] = 1'b1; end
              2'd2: begin m_en[s] = 1'b0; m_irq[s] = 1'b0; end
              default: m_en[s] = 1'b1;
            endcase
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model
  initial begin
    forever begin
      @(negedge m2);
      chk("cmp_cnt_old", int'(cnt0), m_cnt[0]);
      chk("cmp_irq_old", int'(irq0), int'(m_irq[0]));
      chk("cmp_cnt_new", int'(cnt1), m_cnt[1]);
      chk("cmp_irq_new", int'(irq1), int'(m_irq[1]));
    end
  end

  task automatic wr(input logic [1:0] sel, input logic [7:0] data);
    wr_stb = 1'b1; reg_sel = sel; wr_data = data;
    @(negedge m2);
    wr_stb = 1'b0;
  endtask

  task automatic pulse(input int low_n);
    ppu_a12 = 1'b0;
    repeat (low_n) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (5) @(negedge m2);
  endtask

  // Rise whose scanline event lands on the same edge as a register write
  task automatic pulse_wr(input int low_n, input logic [1:0] sel, input logic [7:0] data);
    ppu_a12 = 1'b0;
    repeat (low_n) @(negedge m2);
    ppu_a12 = 1'b1;
    repeat (2) @(negedge m2);
    wr(sel, data);
    repeat (3) @(negedge m2);
  endtask

  initial begin
    repeat (3) @(negedge m2);
    chk("reset_cnt", int'(cnt1), 0);
    chk("reset_irq", int'(irq1), 0);
    rst_n = 1'b1; enable = 1'b1;
    @(negedge m2);

    // Count down 5..0, IRQ on reaching zero
    wr(2'd0, 8'd5); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    for (int i = 0; i < 6; i++) begin
      pulse(8);
      chk("countdown", int'(cnt1), 5 - i);
      chk("countdown_irq", int'(irq1), (i == 5) ? 1 : 0);
    end
    chk("zero_irq_old", int'(irq0), 1);
    wr(2'd2, 8'd0);
    chk("ack_irq", int'(irq1), 0);

    // Filter: 2 low cycles rejected, 3 accepted (counter 0 -> latch 5)
    pulse(2);
    chk("filter_short", int'(cnt1), 0);
    pulse(3);
    chk("filter_ok", int'(cnt1), 5);

    // latch=0: reload event fires both styles; plain zero only fires new style
    wr(2'd0, 8'd0); wr(2'd3, 8'd0); wr(2'd1, 8'd0);
    pulse(8);
    chk("latch0_rel_old", int'(irq0), 1);
    chk("latch0_rel_new", int'(irq1), 1);
    wr(2'd2, 8'd0); wr(2'd3, 8'd0);
    pulse(8);
    chk("latch0_cnt", int'(cnt0), 0);
    chk("latch0_old", int'(irq0), 0);
    chk("latch0_new", int'(irq1), 1);

    // Same-edge reload write and scanline event
    wr(2'd2, 8'd0); wr(2'd0, 8'd4); wr(2'd1, 8'd0);
    pulse(8);
    chk("pre_same_cnt", int'(cnt1), 4);
    pulse_wr(8, 2'd1, 8'd0);
    chk("same_reload", int'(cnt1), 0);
    wr(2'd0, 8'd7);
    pulse(8);
    chk("reload_load7", int'(cnt1), 7);

    // Same-edge disable write and zero-reaching event
    wr(2'd0, 8'd1); wr(2'd1, 8'd0);
    pulse(8);
    chk("pre_dis_cnt", int'(cnt1), 1);
    wr(2'd3, 8'd0);
    pulse_wr(8, 2'd2, 8'd0);
    chk("same_dis_cnt", int'(cnt1), 0);
    chk("same_dis_irq", int'(irq1), 0);
    chk("same_dis_irq_old", int'(irq0), 0);
    pulse(8);
    pulse(8);
    chk("dis_held_irq", int'(irq1), 0);

    // enable=0 mid-count clears everything
    wr(2'd0, 8'd0); wr(2'd3, 8'd0); wr(2'd1, 8'd0);
    pulse(8);
    wr(2'd0, 8'd4);
    pulse(8);
    pulse(8);
    chk("pre_off_cnt", int'(cnt1), 3);
    chk("pre_off_irq", int'(irq1), 1);
    enable = 1'b0;
    @(negedge m2);
    chk("off_cnt", int'(cnt1), 0);
    chk("off_irq", int'(irq1), 0);
    pulse(8);
    chk("off_hold", int'(cnt1), 0);
    enable = 1'b1;
    pulse(8);
    chk("fresh_latch", int'(cnt1), 0);
    chk("fresh_irq_en", int'(irq1), 0);

    // Asynchronous reset mid-operation
    wr(2'd0, 8'd6); wr(2'd1, 8'd0); wr(2'd3, 8'd0);
    pulse(8);
    pulse(8);
    chk("pre_rst_cnt", int'(cnt1), 5);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_cnt", int'(cnt1), 0);
    chk("async_rst_irq", int'(irq1), 0);
    @(negedge m2);
    @(negedge m2);
    rst_n = 1'b1;
    repeat (6) @(negedge m2);
    wr(2'd0, 8'd9);
    pulse(8);
    chk("post_rst_load", int'(cnt1), 9);
    repeat (3) @(negedge m2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
